// File: rtl/cache_wb_if.sv
// rtl/cache_wb_if.sv - CPU-side and memory-side signal bundle for cache_wb
interface cache_wb_if #(
  parameter int AddrBusWidth  = 32,
  parameter int CacheBusWidth = 32,
  parameter int MemBusWidth   = 64
) ();
  // CPU load/store port
  logic [AddrBusWidth-1:0]    addr;
  logic [CacheBusWidth-1:0]   w_data;
  logic [CacheBusWidth/8-1:0] w_strb;
  logic                       re;
  logic                       we;
  logic [CacheBusWidth-1:0]   r_data;
  logic                       busy;
  logic                       done;
  // memory bus controller port
  logic [AddrBusWidth-1:0]    mem_addr;
  logic [MemBusWidth-1:0]     mem_w_data;
  logic [MemBusWidth-1:0]     mem_r_data;
  logic                       mem_re;
  logic                       mem_we;
  logic                       mem_busy;
  logic                       mem_done;

  // the cache itself
  modport slave (
    input  addr, w_data, w_strb, re, we, mem_r_data, mem_busy, mem_done,
    output r_data, busy, done, mem_addr, mem_w_data, mem_re, mem_we
  );

  // the CPU plus memory environment around the cache
  modport master (
    output addr, w_data, w_strb, re, we, mem_r_data, mem_busy, mem_done,
    input  r_data, busy, done, mem_addr, mem_w_data, mem_re, mem_we
  );
endinterface

// File: rtl/cache_wb.sv
// rtl/cache_wb.sv - write-back write-allocate direct-mapped cache; CACHE_WB_STATS_EN adds hit/miss/write-back counters
module cache_wb #(
  parameter int AddrBusWidth  = 32,
  parameter int CacheBusWidth = 32,
  parameter int MemBusWidth   = 64,
  parameter int N             = 256
) (
  input  logic      clk,
  input  logic      rst,
  cache_wb_if.slave bus
`ifdef CACHE_WB_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writebacks
`endif
);
  localparam int StrbW     = CacheBusWidth / 8;
  localparam int Words     = MemBusWidth / CacheBusWidth;
  localparam int WordBits  = $clog2(StrbW);
  localparam int BlockBits = $clog2(Words);
  localparam int IndexBits = $clog2(N);
  localparam int OffBits   = WordBits + BlockBits;
  localparam int TagBits   = AddrBusWidth - OffBits - IndexBits;
  localparam int BlkW      = (BlockBits > 0) ? BlockBits : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RESPOND, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
  } state_t;

  state_t state, state_d;

  logic [AddrBusWidth-1:0]  req_addr;
  logic [CacheBusWidth-1:0] req_wdata;
  logic [StrbW-1:0]         req_strb;
  logic                     req_we;

  logic [TagBits-1:0]     tag_mem  [N];
  logic [MemBusWidth-1:0] data_mem [N];
  logic [N-1:0]           valid_v;
  logic [N-1:0]           dirty_v;

  // registered copy of the indexed line, taken at accept
  logic [TagBits-1:0]     tag_q;
  logic [MemBusWidth-1:0] line_q;
  logic                   valid_q;
  logic                   dirty_q;

  logic [CacheBusWidth-1:0] r_data_q;
  logic [AddrBusWidth-1:0]  mem_addr_q;
  logic [MemBusWidth-1:0]   mem_w_data_q;

  logic                 accept, hit, fill_done, mem_re_c, mem_we_c;
  logic [IndexBits-1:0] acc_idx, req_idx;
  logic [TagBits-1:0]   req_tag;
  logic [BlkW-1:0]      req_blk;

  assign acc_idx   = bus.addr[OffBits +: IndexBits];
  assign req_idx   = req_addr[OffBits +: IndexBits];
  assign req_tag   = req_addr[AddrBusWidth-1 -: TagBits];
  // masking keeps the word select at zero when a line holds a single word
  assign req_blk   = BlkW'(req_addr >> WordBits) & BlkW'(Words - 1);
  assign accept    = (state == IDLE) && (bus.re || bus.we);
  assign hit       = valid_q && (tag_q == req_tag);
  assign fill_done = (state == FILL_WAIT) && bus.mem_done;

  function automatic logic [MemBusWidth-1:0] merge_word(
    input logic [MemBusWidth-1:0]   line,
    input logic [BlkW-1:0]          blk,
    input logic [CacheBusWidth-1:0] w,
    input logic [StrbW-1:0]         strb
  );
    logic [MemBusWidth-1:0] m;
    m = line;
    for (int i = 0; i < StrbW; i++) begin
      if (strb[i]) m[int'(blk)*CacheBusWidth + i*8 +: 8] = w[i*8 +: 8];
    end
    return m;
  endfunction

  // next-state and one-cycle memory command decode
  always_comb begin
    state_d  = state;
    mem_re_c = 1'b0;
    mem_we_c = 1'b0;
    case (state)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)                     state_d = RESPOND;
        else if (valid_q && dirty_q) state_d = WB_REQ;
        else                         state_d = FILL_REQ;
      end
      WB_REQ: begin
        if (!bus.mem_busy) begin
          mem_we_c = 1'b1;
          state_d  = WB_WAIT;
        end
      end
      WB_WAIT:   if (bus.mem_done) state_d = FILL_REQ;
      FILL_REQ: begin
        if (!bus.mem_busy) begin
          mem_re_c = 1'b1;
          state_d  = FILL_WAIT;
        end
      end
      FILL_WAIT: if (bus.mem_done) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // state, request latch, valid/dirty tracking and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_strb     <= '0;
      req_we       <= 1'b0;
      valid_v      <= '0;
      dirty_v      <= '0;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      r_data_q     <= '0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        req_addr  <= bus.addr;
        req_wdata <= bus.w_data;
        req_strb  <= bus.w_strb;
        req_we    <= bus.we;
        valid_q   <= valid_v[acc_idx];
        dirty_q   <= dirty_v[acc_idx];
      end
      if (state == LOOKUP) begin
        if (hit) begin
          if (!req_we) r_data_q <= line_q[int'(req_blk)*CacheBusWidth +: CacheBusWidth];
        end else if (valid_q && dirty_q) begin
          mem_addr_q   <= {tag_q, req_idx, {OffBits{1'b0}}};
          mem_w_data_q <= line_q;
        end else begin
          mem_addr_q <= {req_tag, req_idx, {OffBits{1'b0}}};
        end
      end
      if (state == WB_WAIT && bus.mem_done) mem_addr_q <= {req_tag, req_idx, {OffBits{1'b0}}};
      if (fill_done) begin
        valid_v[req_idx] <= 1'b1;
        dirty_v[req_idx] <= req_we;
        if (!req_we) r_data_q <= bus.mem_r_data[int'(req_blk)*CacheBusWidth +: CacheBusWidth];
      end
      if (state == RESPOND && req_we) dirty_v[req_idx] <= 1'b1;
    end
  end

  // tag/data arrays and the lookup snapshot; no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q  <= tag_mem[acc_idx];
      line_q <= data_mem[acc_idx];
    end
    if (fill_done) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= req_we ? merge_word(bus.mem_r_data, req_blk, req_wdata, req_strb)
                                  : bus.mem_r_data;
      line_q            <= bus.mem_r_data;
    end
    if (state == RESPOND && req_we) data_mem[req_idx] <= merge_word(line_q, req_blk, req_wdata, req_strb);
  end

`ifdef CACHE_WB_STATS_EN
  // saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == LOOKUP && hit && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      if (state == LOOKUP && !hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (mem_we_c && stat_writebacks != '1) stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif

  assign bus.r_data     = r_data_q;
  assign bus.busy       = (state != IDLE) && (state != RESPOND);
  assign bus.done       = (state == RESPOND);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.mem_re     = mem_re_c;
  assign bus.mem_we     = mem_we_c;
endmodule

// File: tb/tb_cache_wb.sv
// tb/tb_cache_wb.sv - self-checking bench for cache_wb
module tb_cache_wb;
  localparam int AW = 32, CW = 32, MW = 64, NL = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_wb_if #(.AddrBusWidth(AW), .CacheBusWidth(CW), .MemBusWidth(MW)) bus ();

`ifdef CACHE_WB_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  cache_wb #(.AddrBusWidth(AW), .CacheBusWidth(CW), .MemBusWidth(MW), .N(NL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHE_WB_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [63:0] mem_arr [logic [31:0]];
  int          n_re = 0, n_we = 0, both_high = 0;
  logic [31:0] last_re_addr, last_we_addr, pend_addr;
  logic [63:0] last_we_data;
  int          lat_cfg = 1;
  int          cd = 0;
  bit          busy_rand = 1'b0, busy_force = 1'b0;

  function automatic logic [63:0] mem_default(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [63:0] env_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return mem_default(a);
  endfunction

  always @(negedge clk) begin
    bus.mem_done = 1'b0;
    if (!rst) cd = 0;
    else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          bus.mem_done   = 1'b1;
          bus.mem_r_data = env_rd(pend_addr);
        end
      end
      if (bus.mem_re && bus.mem_we) both_high++;
      if (bus.mem_re) begin
        n_re++;
        last_re_addr = bus.mem_addr;
        pend_addr    = bus.mem_addr;
        cd           = lat_cfg;
      end
      if (bus.mem_we) begin
        n_we++;
        last_we_addr          = bus.mem_addr;
        last_we_data          = bus.mem_w_data;
        mem_arr[bus.mem_addr] = bus.mem_w_data;
        cd                    = lat_cfg;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.mem_busy = busy_rand ? ($urandom_range(0, 2) == 0) : busy_force;
  end

  // ---------------- CPU request driver ----------------
  task automatic drive_req(input logic [31:0] a, input bit w, input bit both,
                           input logic [31:0] wd, input logic [3:0] st);
    @(posedge clk); #1;
    bus.addr = a; bus.w_data = wd; bus.w_strb = st;
    bus.we = w; bus.re = ~w | both;
    @(posedge clk); #1;
    bus.re = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] rd);
    lat = -1; rd = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.done) begin lat = c; rd = bus.r_data; break; end
    end
  endtask

  task automatic run_req(input logic [31:0] a, input bit w, input bit both, input logic [31:0] wd,
                         input logic [3:0] st, output int lat, output logic [31:0] rd);
    drive_req(a, w, both, wd, st);
    wait_done(lat, rd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_r_data"}, bus.r_data, 0);
    chk({tag, "_mem_re"}, bus.mem_re, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_w_data"}, bus.mem_w_data, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] addr; bit w; bit both; logic [31:0] wd; logic [3:0] st;
    int lat; bit ck_rd; logic [31:0] rd;
    int nre; int nwe; logic [31:0] re_addr; logic [31:0] we_addr; logic [63:0] we_data;
  } vec_t;
  vec_t tv [8];

  // ---------------- reference model for random phase ----------------
  logic [63:0] ref_mem [logic [31:0]];
  bit          rv  [NL];
  bit          rdt [NL];
  logic [31:0] rt  [NL];
  logic [63:0] rl  [NL];

  initial begin : main
    int          lat, b_re, b_we, idx, tg, wsel;
    logic [31:0] rd, a, wd, la, exp_rd, exp_we_addr;
    logic [63:0] exp_we_data, dv;
    logic [3:0]  st;
    bit          w, ok, exp_re, exp_we;

    bus.addr = '0; bus.w_data = '0; bus.w_strb = '0; bus.re = 1'b0; bus.we = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    mem_arr[32'h1000] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem_arr[32'h2000] = 64'h1111_2222_3333_4444;
    mem_arr[32'h3000] = 64'h5555_6666_7777_8888;

    tv[0] = '{32'h1004, 1'b0, 1'b0, 32'h0, 4'h0, 4, 1'b1, 32'hAAAABBBB, 1, 0, 32'h1000, 32'h0, 64'h0};
    tv[1] = '{32'h1000, 1'b0, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'hCCCCDDDD, 0, 0, 32'h0, 32'h0, 64'h0};
    tv[2] = '{32'h1000, 1'b1, 1'b1, 32'h11223344, 4'b0011, 2, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0, 64'h0};
    tv[3] = '{32'h1000, 1'b0, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'hCCCC3344, 0, 0, 32'h0, 32'h0, 64'h0};
    tv[4] = '{32'h2004, 1'b0, 1'b0, 32'h0, 4'h0, 6, 1'b1, 32'h11112222, 1, 1, 32'h2000, 32'h1000,
              64'hAAAABBBB_CCCC3344};
    tv[5] = '{32'h3000, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 4, 1'b0, 32'h0, 1, 0, 32'h3000, 32'h0, 64'h0};
    tv[6] = '{32'h3000, 1'b0, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 64'h0};
    tv[7] = '{32'h1000, 1'b0, 1'b0, 32'h0, 4'h0, 6, 1'b1, 32'hCCCC3344, 1, 1, 32'h1000, 32'h3000,
              64'h55556666_DEADBEEF};

    for (int i = 0; i < 8; i++) begin
      b_re = n_re; b_we = n_we; lat_cfg = 1;
      run_req(tv[i].addr, tv[i].w, tv[i].both, tv[i].wd, tv[i].st, lat, rd);
      chk($sformatf("v%0d_latency", i), lat, tv[i].lat);
      if (tv[i].ck_rd) chk($sformatf("v%0d_r_data", i), rd, tv[i].rd);
      chk($sformatf("v%0d_mem_re_count", i), n_re - b_re, tv[i].nre);
      chk($sformatf("v%0d_mem_we_count", i), n_we - b_we, tv[i].nwe);
      if (tv[i].nre > 0) chk($sformatf("v%0d_mem_re_addr", i), last_re_addr, tv[i].re_addr);
      if (tv[i].nwe > 0) begin
        chk($sformatf("v%0d_mem_we_addr", i), last_we_addr, tv[i].we_addr);
        chk($sformatf("v%0d_mem_w_data", i), last_we_data, tv[i].we_data);
      end
    end

    // mem_busy held for five FILL_REQ cycles
    busy_force = 1'b1; b_re = n_re; ok = 1'b1;
    drive_req(32'h1008, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (!bus.busy || bus.mem_re) ok = 1'b0;
    end
    chk("busy_hold_no_mem_re", {63'h0, ok}, 64'h1);
    chk("busy_hold_re_count", n_re - b_re, 0);
    busy_force = 1'b0;
    lat = -1; rd = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.done) begin lat = c; rd = bus.r_data; break; end
      if (!bus.busy) ok = 1'b0;
    end
    dv = mem_default(32'h1008);
    chk("busy_hold_completed", {63'h0, lat > 0}, 64'h1);
    chk("busy_hold_busy_stays", {63'h0, ok}, 64'h1);
    chk("busy_hold_single_re", n_re - b_re, 1);
    chk("busy_hold_re_addr", last_re_addr, 32'h1008);
    chk("busy_hold_r_data", rd, dv[31:0]);

    // reset while waiting for fill data
    lat_cfg = 8; b_re = n_re; ok = 1'b0;
    drive_req(32'h2000, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (n_re != b_re) begin ok = 1'b1; break; end
    end
    chk("rst_mid_reached_fill_wait", {63'h0, ok}, 64'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.mem_re || bus.mem_we) ok = 1'b0;
    end
    chk("rst_mid_quiet", {63'h0, ok}, 64'h1);
    #2 rst = 1'b1;
    lat_cfg = 1; b_re = n_re;
    run_req(32'h2000, 1'b0, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("rst_after_latency", lat, 4);
    chk("rst_after_re_count", n_re - b_re, 1);
    chk("rst_after_re_addr", last_re_addr, 32'h2000);
    chk("rst_after_r_data", rd, 32'h33334444);

    // randomized traffic against the reference model
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < NL; i++) begin rv[i] = 1'b0; rdt[i] = 1'b0; end
    busy_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      tg   = 8 + $urandom_range(0, 2);
      idx  = $urandom_range(0, 3);
      wsel = $urandom_range(0, 1);
      a    = (tg << 11) | (idx << 3) | (wsel << 2);
      w    = $urandom_range(0, 1);
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      la   = a & ~32'h7;
      exp_re = 1'b0; exp_we = 1'b0; exp_rd = '0; exp_we_addr = '0; exp_we_data = '0;
      if (!(rv[idx] && rt[idx] == tg)) begin
        if (rv[idx] && rdt[idx]) begin
          exp_we      = 1'b1;
          exp_we_addr = (rt[idx] << 11) | (idx << 3);
          exp_we_data = rl[idx];
          ref_mem[exp_we_addr] = rl[idx];
        end
        exp_re  = 1'b1;
        rl[idx] = ref_mem.exists(la) ? ref_mem[la] : mem_default(la);
        rv[idx] = 1'b1; rt[idx] = tg; rdt[idx] = 1'b0;
      end
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) rl[idx][wsel*32 + b*8 +: 8] = wd[b*8 +: 8];
        rdt[idx] = 1'b1;
      end else begin
        exp_rd = rl[idx][wsel*32 +: 32];
      end
      b_re = n_re; b_we = n_we; lat_cfg = $urandom_range(1, 3);
      run_req(a, w, 1'b0, wd, st, lat, rd);
      chk($sformatf("rnd%0d_completed", n), {63'h0, lat > 0}, 64'h1);
      chk($sformatf("rnd%0d_mem_re_count", n), n_re - b_re, {63'h0, exp_re});
      chk($sformatf("rnd%0d_mem_we_count", n), n_we - b_we, {63'h0, exp_we});
      if (exp_re) chk($sformatf("rnd%0d_mem_re_addr", n), last_re_addr, la);
      if (exp_we) begin
        chk($sformatf("rnd%0d_mem_we_addr", n), last_we_addr, exp_we_addr);
        chk($sformatf("rnd%0d_mem_w_data", n), last_we_data, exp_we_data);
      end
      if (!w) chk($sformatf("rnd%0d_r_data", n), rd, exp_rd);
      if (!exp_re) chk($sformatf("rnd%0d_hit_latency", n), lat, 2);
    end
    busy_rand = 1'b0;

    chk("mem_re_we_exclusive", both_high, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
